// File: rtl/imem_pkg.sv
// Shared constants, FSM state type and the fetch/load address check for the instruction memory responder.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // offset is (addr - base) with wrap, so addresses below the base land far above the window.
  function automatic logic addr_fault(input logic [1:0]  addr_lsb,
                                      input logic [63:0] offset,
                                      input logic [63:0] window_bytes);
    return (addr_lsb != 2'b00) || (offset >= window_bytes);
  endfunction

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response handshake plus memory load port; master is the PC/boot side, slave the responder.
interface imem_fetch_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_instr;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_fault;
  logic                  ld_en;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );
endinterface

// File: rtl/imem_fetch_responder_array.sv
// Instruction storage: synchronous read, read-before-write; second read port only with IMEM_PREFETCH_EN.
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
`ifdef IMEM_PREFETCH_EN
  input  logic                  pf_rd_en,
  input  logic [IDX_W-1:0]      pf_rd_idx,
  output logic [DATA_WIDTH-1:0] pf_rd_data,
`endif
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

`ifdef IMEM_PREFETCH_EN
  logic [DATA_WIDTH-1:0] pf_rd_data_q, pf_rd_data_d;

  always_comb begin
    pf_rd_data_d = pf_rd_data_q;
    if (pf_rd_en) pf_rd_data_d = mem[pf_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) pf_rd_data_q <= '0;
    else     pf_rd_data_q <= pf_rd_data_d;
  end

  assign pf_rd_data = pf_rd_data_q;
`endif

endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch responder: rsp_valid WAIT_CYCLES+1 edges after the accepting cycle (1 on a prefetch hit when IMEM_PREFETCH_EN is defined).
// One fetch in flight; req_ready only in IDLE, response held stable while rsp_ready is low.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(RESET_VECTOR),
  parameter int unsigned           DEPTH_WORDS = 1024,
  parameter int unsigned           WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_fetch_responder_if.slave bus
);

  localparam int unsigned IDX_W        = $clog2(DEPTH_WORDS);
  localparam logic [63:0] WINDOW_BYTES = 64'(DEPTH_WORDS) << 2;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic                  rsp_fault_q, rsp_fault_d;

  logic                  accept, pf_hit, enter_resp;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_offset, ld_offset;
  logic                  rd_fault, ld_fault;
  logic [DATA_WIDTH-1:0] arr_rd_data;

  assign accept     = (state_q == IDLE) && bus.req_valid;
  // In IDLE the read targets the live request so zero-wait and prefetch-hit paths need no capture cycle.
  assign rd_addr    = (state_q == IDLE) ? bus.req_addr : addr_q;
  assign rd_offset  = rd_addr - BASE_ADDR;
  assign ld_offset  = bus.ld_addr - BASE_ADDR;
  assign rd_fault   = addr_fault(rd_addr[1:0], 64'(rd_offset), WINDOW_BYTES);
  assign ld_fault   = addr_fault(bus.ld_addr[1:0], 64'(ld_offset), WINDOW_BYTES);
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

`ifdef IMEM_PREFETCH_EN
  logic                  pf_valid_q, pf_valid_d;
  logic [ADDR_WIDTH-1:0] pf_addr_q, pf_addr_d;
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] hit_instr_q, hit_instr_d;
  logic [ADDR_WIDTH-1:0] pf_rd_addr, pf_offset;
  logic                  pf_fault;
  logic [DATA_WIDTH-1:0] pf_buf;

  assign pf_hit     = accept && pf_valid_q && (bus.req_addr == pf_addr_q);
  assign pf_rd_addr = rd_addr + ADDR_WIDTH'(4);
  assign pf_offset  = pf_rd_addr - BASE_ADDR;
  assign pf_fault   = addr_fault(pf_rd_addr[1:0], 64'(pf_offset), WINDOW_BYTES);

  always_comb begin
    pf_valid_d  = pf_valid_q;
    pf_addr_d   = pf_addr_q;
    hit_d       = hit_q;
    hit_instr_d = hit_instr_q;
    if (enter_resp && !rd_fault) begin
      pf_valid_d = !pf_fault;
      pf_addr_d  = pf_rd_addr;
    end
    // pf_buf is refilled on the same edge, so a hit keeps its own copy for the response.
    if (enter_resp) begin
      hit_d       = pf_hit;
      hit_instr_d = pf_buf;
    end
    if (bus.ld_en) pf_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pf_valid_q  <= 1'b0;
      pf_addr_q   <= '0;
      hit_q       <= 1'b0;
      hit_instr_q <= '0;
    end else begin
      pf_valid_q  <= pf_valid_d;
      pf_addr_q   <= pf_addr_d;
      hit_q       <= hit_d;
      hit_instr_q <= hit_instr_d;
    end
  end
`else
  assign pf_hit = 1'b0;
`endif

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_WIDTH  (DATA_WIDTH),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (enter_resp && !pf_hit),
    .rd_idx     (rd_offset[IDX_W+1:2]),
    .rd_data    (arr_rd_data),
`ifdef IMEM_PREFETCH_EN
    .pf_rd_en   (enter_resp && !rd_fault),
    .pf_rd_idx  (pf_offset[IDX_W+1:2]),
    .pf_rd_data (pf_buf),
`endif
    .wr_en      (bus.ld_en && !ld_fault),
    .wr_idx     (ld_offset[IDX_W+1:2]),
    .wr_data    (bus.ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (pf_hit || WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_addr  = rsp_addr_q;
    bus.rsp_fault = rsp_fault_q;
`ifdef IMEM_PREFETCH_EN
    bus.rsp_instr = rsp_fault_q ? DATA_WIDTH'(NOP_INSTR) : (hit_q ? hit_instr_q : arr_rd_data);
`else
    bus.rsp_instr = rsp_fault_q ? DATA_WIDTH'(NOP_INSTR) : arr_rd_data;
`endif
  end

  always_comb begin
    addr_d      = accept ? bus.req_addr : addr_q;
    cnt_d       = cnt_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_fault_d = rsp_fault_q;
    if (state_q == IDLE && state_d == WAIT)      cnt_d = 4'(WAIT_CYCLES - 1);
    else if (state_q == WAIT && cnt_q != 4'd0)   cnt_d = cnt_q - 4'd1;
    if (enter_resp) begin
      rsp_addr_d  = rd_addr;
      rsp_fault_d = rd_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      rsp_addr_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder (WAIT_CYCLES=1, DEPTH_WORDS=1024); inputs driven and outputs sampled on negedge.
module tb_imem_fetch_responder;
  import imem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_fetch_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  imem_fetch_responder #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .BASE_ADDR   (32'hBFC0_0000),
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          lat;
  logic [31:0] instr, raddr;
  logic        fault;

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
    @(negedge clk);
    bus.ld_en = 1'b0;
  endtask

  // Called at a negedge with the responder idle; lat counts edges from the accepting edge onwards.
  task automatic do_fetch(input logic [31:0] a, output int l, output logic [31:0] i,
                          output logic [31:0] ra, output logic f);
    bus.req_valid = 1'b1; bus.req_addr = a;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_addr = 32'h0;
    l = 1;
    while (bus.rsp_valid !== 1'b1 && l < 20) begin
      @(negedge clk);
      l++;
    end
    i = bus.rsp_instr; ra = bus.rsp_addr; f = bus.rsp_fault;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_instr !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_instr: got %h want 0", bus.rsp_instr); end
    n_checks++; if (bus.rsp_addr !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_addr: got %h want 0", bus.rsp_addr); end
    n_checks++; if (bus.rsp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_fault: got %b want 0", bus.rsp_fault); end
    rst = 1'b0;
  endtask

  task automatic test_fetch_basic;
    do_load(32'hBFC0_0000, 32'h0050_0093);
    do_load(32'hBFC0_0004, 32'h00A0_0113);
    do_load(32'hBFC0_0FFC, 32'h1234_5678);
    do_fetch(32'hBFC0_0000, lat, instr, raddr, fault);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", lat); end
    n_checks++; if (instr !== 32'h0050_0093) begin n_fail++; $display("FAIL basic_instr: got %h want 00500093", instr); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL basic_fault: got %b want 0", fault); end
    n_checks++; if (raddr !== 32'hBFC0_0000) begin n_fail++; $display("FAIL basic_addr: got %h want bfc00000", raddr); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle_ready: got %b want 1", bus.req_ready); end
    do_fetch(32'hBFC0_0FFC, lat, instr, raddr, fault);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lastword_latency: got %0d want 2", lat); end
    n_checks++; if (instr !== 32'h1234_5678) begin n_fail++; $display("FAIL lastword_instr: got %h want 12345678", instr); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL lastword_fault: got %b want 0", fault); end
  endtask

  task automatic test_fault;
    do_fetch(32'hBFC0_0002, lat, instr, raddr, fault);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL misalign_latency: got %0d want 2", lat); end
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL misalign_fault: got %b want 1", fault); end
    n_checks++; if (instr !== NOP_INSTR) begin n_fail++; $display("FAIL misalign_instr: got %h want 00000013", instr); end
    n_checks++; if (raddr !== 32'hBFC0_0002) begin n_fail++; $display("FAIL misalign_addr: got %h want bfc00002", raddr); end
    do_fetch(32'hBFBF_FFFC, lat, instr, raddr, fault);
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL below_fault: got %b want 1", fault); end
    n_checks++; if (instr !== NOP_INSTR) begin n_fail++; $display("FAIL below_instr: got %h want 00000013", instr); end
    do_fetch(32'hBFC0_1000, lat, instr, raddr, fault);
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL above_fault: got %b want 1", fault); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL above_latency: got %0d want 2", lat); end
    // Faulting loads would alias word 0 if not dropped.
    do_load(32'hBFC0_1000, 32'hDEAD_BEEF);
    do_load(32'hBFC0_0001, 32'hDEAD_BEEF);
    do_fetch(32'hBFC0_0000, lat, instr, raddr, fault);
    n_checks++; if (instr !== 32'h0050_0093) begin n_fail++; $display("FAIL bad_load_dropped: got %h want 00500093", instr); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL bad_load_fault: got %b want 0", fault); end
  endtask

  task automatic test_backpressure;
    bus.req_valid = 1'b1; bus.req_addr = 32'hBFC0_0004;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_arrives: got %b want 1", bus.rsp_valid); end
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1; bus.req_addr = 32'hBFC0_0000;
      bus.ld_en = (i == 0); bus.ld_addr = 32'hBFC0_0004; bus.ld_data = 32'hCAFE_0001;
      @(negedge clk);
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
      n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, bus.req_ready); end
      n_checks++; if (bus.rsp_instr !== 32'h00A0_0113) begin n_fail++; $display("FAIL bp_hold_instr[%0d]: got %h want 00a00113", i, bus.rsp_instr); end
      n_checks++; if (bus.rsp_addr !== 32'hBFC0_0004) begin n_fail++; $display("FAIL bp_hold_addr[%0d]: got %h want bfc00004", i, bus.rsp_addr); end
    end
    bus.ld_en = 1'b0; bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus.req_ready); end
    do_fetch(32'hBFC0_0004, lat, instr, raddr, fault);
    n_checks++; if (instr !== 32'hCAFE_0001) begin n_fail++; $display("FAIL bp_reload_instr: got %h want cafe0001", instr); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL bp_reload_latency: got %0d want 2", lat); end
  endtask

  task automatic test_read_before_write;
    do_load(32'hBFC0_0008, 32'h1111_1111);
    bus.req_valid = 1'b1; bus.req_addr = 32'hBFC0_0008;
    @(negedge clk);
    bus.req_valid = 1'b0;
    // The next edge enters RESP and reads the word; write it on that same edge.
    bus.ld_en = 1'b1; bus.ld_addr = 32'hBFC0_0008; bus.ld_data = 32'h2222_2222;
    @(negedge clk);
    bus.ld_en = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rbw_valid: got %b want 1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_instr !== 32'h1111_1111) begin n_fail++; $display("FAIL rbw_old_data: got %h want 11111111", bus.rsp_instr); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    do_fetch(32'hBFC0_0008, lat, instr, raddr, fault);
    n_checks++; if (instr !== 32'h2222_2222) begin n_fail++; $display("FAIL rbw_new_data: got %h want 22222222", instr); end
  endtask

  task automatic test_back_to_back;
    int seen, first, second;
    logic [31:0] first_instr;
    seen = 0; first = 0; second = 0; first_instr = 32'h0;
    bus.req_valid = 1'b1; bus.req_addr = 32'hBFC0_0000; bus.rsp_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        seen++;
        if (seen == 1) begin first = i; first_instr = bus.rsp_instr; end
        else if (seen == 2) second = i;
      end
    end
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    n_checks++; if (seen !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", seen); end
    n_checks++; if (first !== 2) begin n_fail++; $display("FAIL b2b_first: got %0d want 2", first); end
    n_checks++; if (second - first !== 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 3", second - first); end
    n_checks++; if (first_instr !== 32'h0050_0093) begin n_fail++; $display("FAIL b2b_instr: got %h want 00500093", first_instr); end
  endtask

  task automatic test_reset_mid;
    int late;
    late = 0;
    bus.req_valid = 1'b1; bus.req_addr = 32'hBFC0_0FFC;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", bus.req_ready); end
    n_checks++; if (bus.rsp_instr !== 32'h0) begin n_fail++; $display("FAIL rstmid_instr: got %h want 0", bus.rsp_instr); end
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) late++;
    end
    n_checks++; if (late !== 0) begin n_fail++; $display("FAIL rstmid_ghost_rsp: got %0d want 0", late); end
  endtask

`ifdef IMEM_PREFETCH_EN
  task automatic test_prefetch;
    do_fetch(32'hBFC0_0000, lat, instr, raddr, fault);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL pf_cold_latency: got %0d want 2", lat); end
    do_fetch(32'hBFC0_0004, lat, instr, raddr, fault);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL pf_hit_latency: got %0d want 1", lat); end
    n_checks++; if (instr !== 32'hCAFE_0001) begin n_fail++; $display("FAIL pf_hit_instr: got %h want cafe0001", instr); end
    do_fetch(32'hBFC0_0008, lat, instr, raddr, fault);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL pf_chain_latency: got %0d want 1", lat); end
    n_checks++; if (instr !== 32'h2222_2222) begin n_fail++; $display("FAIL pf_chain_instr: got %h want 22222222", instr); end
    do_load(32'hBFC0_000C, 32'hABCD_000C);
    do_fetch(32'hBFC0_000C, lat, instr, raddr, fault);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL pf_ld_clear_latency: got %0d want 2", lat); end
    n_checks++; if (instr !== 32'hABCD_000C) begin n_fail++; $display("FAIL pf_ld_clear_instr: got %h want abcd000c", instr); end
    do_fetch(32'hBFC0_0000, lat, instr, raddr, fault);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_fetch(32'hBFC0_0004, lat, instr, raddr, fault);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL pf_rst_clear_latency: got %0d want 2", lat); end
    do_fetch(32'hBFC0_0000, lat, instr, raddr, fault);
    do_load(32'hBFC0_0004, 32'hBEEF_0004);
    do_fetch(32'hBFC0_0004, lat, instr, raddr, fault);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL pf_stale_latency: got %0d want 2", lat); end
    n_checks++; if (instr !== 32'hBEEF_0004) begin n_fail++; $display("FAIL pf_stale_instr: got %h want beef0004", instr); end
  endtask
`else
  task automatic test_no_prefetch;
    do_fetch(32'hBFC0_0000, lat, instr, raddr, fault);
    do_fetch(32'hBFC0_0004, lat, instr, raddr, fault);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL seq_latency: got %0d want 2", lat); end
    n_checks++; if (instr !== 32'hCAFE_0001) begin n_fail++; $display("FAIL seq_instr: got %h want cafe0001", instr); end
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.rsp_ready = 1'b0;
    bus.ld_en = 1'b0; bus.ld_addr = 32'h0; bus.ld_data = 32'h0;
    rst = 1'b1;
    test_reset;
    test_fetch_basic;
    test_fault;
    test_backpressure;
    test_read_before_write;
    test_back_to_back;
    test_reset_mid;
`ifdef IMEM_PREFETCH_EN
    test_prefetch;
`else
    test_no_prefetch;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
